// File: rtl/path_replayer.sv
// path_replayer: drains the direction stack into a local buffer,
// then replays the entries oldest-first over a valid/ready stream.
module path_replayer #(
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stk_empty,
  input  logic [1:0]    stk_data,
  output logic          stk_pop,
  output logic [1:0]    dir_out,
  output logic          dir_valid,
  input  logic          dir_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CAPT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          wr_en;
  logic [1:0]    buf_q [DEPTH];

  // State, counter, read index and overflow flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Capture buffer; contents need no reset, count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[cnt_q[AW-1:0]] <= stk_data;
    end
  end

  // Next-state logic; the pop count doubles as the write index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    stk_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          rd_d    = '0;
          ovf_d   = 1'b0;
          state_d = S_POP;
        end
      end
      S_POP: begin
        if (stk_empty) begin
          if (cnt_q != '0) begin
            rd_d    = cnt_q - ONE;
            state_d = S_EMIT;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == FULL) begin
          ovf_d   = 1'b1;
          rd_d    = cnt_q - ONE;
          state_d = S_EMIT;
        end else begin
          stk_pop = 1'b1;
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        wr_en   = 1'b1;
        cnt_d   = cnt_q + ONE;
        state_d = S_POP;
      end
      S_EMIT: begin
        if (dir_ready) begin
          if (rd_q == '0) begin
            state_d = S_DONE;
          end else begin
            rd_d = rd_q - ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; dir_out is forced low when not valid.
  always_comb begin
    dir_valid = (state_q == S_EMIT);
    dir_out   = dir_valid ? buf_q[rd_q[AW-1:0]] : 2'b00;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    count     = cnt_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_path_replayer.sv
// tb_path_replayer: stack model, random pushes, scoreboard of expected
// replay order, handshake monitor and timing checks.
module tb_path_replayer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stk_empty;
  logic [1:0] stk_data = 2'b00;
  logic       stk_pop;
  logic [1:0] dir_out;
  logic       dir_valid;
  logic       dir_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [8:0] count;
  logic       overflow;

  path_replayer #(.DEPTH(256), .CW(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stk_empty (stk_empty),
    .stk_data  (stk_data),
    .stk_pop   (stk_pop),
    .dir_out   (dir_out),
    .dir_valid (dir_valid),
    .dir_ready (dir_ready),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_q[$];
  logic [1:0] smem [256];
  int         sp = 0;
  logic       push_en = 1'b0;
  logic [1:0] push_d = 2'b00;
  logic       pop_lat = 1'b0;
  int         pops = 0;
  int         hs_cnt = 0;
  int         hs_stop = 0;
  int         rmode = 1;

  assign stk_empty = (sp == 0);

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Behavioural stack: push from stimulus, pop returns top next cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (push_en) begin
        smem[sp] <= push_d;
        sp <= sp + 1;
      end else if (pop_lat && sp > 0) begin
        stk_data <= smem[sp-1];
        sp <= sp - 1;
      end
    end
  end

  // Consumer ready driver.
  initial begin
    logic [1:0] pat [5];
    int rk;
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
    rk = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: dir_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!busy) begin
            rk = 0;
            dir_ready = 1'b0;
          end else if (dir_valid) begin
            dir_ready = (rk < 5) ? pat[rk][0] : 1'b1;
            rk++;
          end
        end
        3: dir_ready = (hs_cnt < hs_stop);
        default: dir_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pops on handshakes, protocol checks.
  initial begin
    logic       stall_prev;
    logic [1:0] dir_prev;
    logic       pop_prev;
    logic       done_prev;
    stall_prev = 1'b0;
    dir_prev = 2'b00;
    pop_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      pop_lat = stk_pop;
      if (rst) begin
        stall_prev = 1'b0;
        pop_prev = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", int'(dir_valid), 1);
          chk("hold_data", int'(dir_out), int'(dir_prev));
        end
        if (!dir_valid)
          chk("idle_dir_zero", int'(dir_out), 0);
        if (dir_valid && dir_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0)
            chk("unexpected_xfer", int'(dir_out), -1);
          else
            chk("replay_data", int'(dir_out), int'(exp_q.pop_front()));
        end
        if (stk_pop) begin
          pops++;
          chk("pop_not_empty", int'(stk_empty), 0);
          chk("pop_not_b2b", int'(pop_prev), 0);
        end
        if (done && done_prev)
          chk("done_one_cycle", 1, 0);
        stall_prev = dir_valid && !dir_ready;
        dir_prev = dir_out;
        pop_prev = stk_pop;
        done_prev = done;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_n(input int n, input int pmode);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      case (pmode)
        1: d = 2'(i % 4);
        2: d = 2'((i % 3) + 1);
        default: d = 2'($urandom_range(0, 3));
      endcase
      @(negedge clk);
      push_en = 1'b1;
      push_d = d;
      exp_q.push_back(d);
    end
    @(negedge clk);
    push_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_case(input int n, input int pmode, input int rm,
                          input bit restart);
    int k, fv, hs0, p0;
    bit got;
    push_n(n, pmode);
    rmode = rm;
    hs0 = hs_cnt;
    p0 = pops;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    fv = -1;
    got = 1'b0;
    while (k < 3000 && !got) begin
      @(posedge clk);
      k++;
      #1;
      if (dir_valid && fv < 0) fv = k;
      if (done) begin
        got = 1'b1;
        start = restart;
      end else begin
        start = restart && (k == 3 || (fv > 0 && k == fv + 1));
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_pulse_end", int'(done), 0);
      chk("idle_after_done", int'(busy), 0);
      @(posedge clk);
      #1;
      chk("start_in_done_ignored", int'(busy), 0);
    end else begin
      start = 1'b0;
      chk("done_timeout", 0, 1);
    end
    if (n > 0) chk("first_valid_edge", fv, 2 * n + 1);
    else chk("no_valid_when_empty", fv, -1);
    if (rm == 1) chk("done_edge", k, 3 * n + 1);
    chk("count", int'(count), n);
    chk("overflow", int'(overflow), 0);
    chk("stack_empty_end", int'(stk_empty), 1);
    chk("pop_total", pops - p0, n);
    chk("xfer_total", hs_cnt - hs0, n);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pop", int'(stk_pop), 0);
    chk("rst_dir", int'(dir_out), 0);
    chk("rst_valid", int'(dir_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    run_case(3, 2, 1, 1'b0);
    run_case(0, 0, 1, 1'b0);
    run_case(2, 0, 2, 1'b0);
    run_case(256, 1, 1, 1'b0);

    push_n(3, 2);
    rmode = 3;
    hs_stop = hs_cnt + 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (k < 200 && !(hs_cnt >= hs_stop && dir_valid)) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("reached_emit", int'(k < 200), 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_pop", int'(stk_pop), 0);
    chk("mid_rst_dir", int'(dir_out), 0);
    chk("mid_rst_valid", int'(dir_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stay_idle", int'(busy), 0);
    run_case(0, 0, 1, 1'b0);

    run_case(5, 0, 1, 1'b1);
    for (int i = 0; i < 8; i++)
      run_case($urandom_range(1, 20), 0, 0, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
